// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Bus-master instruction fetcher. Issues word reads over an
//               Avalon-style read port starting at RESET_VECTOR, buffers the
//               returned words in a small FIFO and hands them to decode with a
//               valid/ready handshake. A redirect flushes buffered words and
//               drops any read still outstanding on the bus.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   address, read     instruction read request (word-aligned byte address)
//   waitrequest       memory stall; data valid when read=1 and waitrequest=0
//   readdata          returned instruction word
//   instr_valid/instr/instr_pc/instr_ready   decode handshake (FIFO head)
//   redirect_valid/redirect_pc               branch/jump redirect strobe
//   fetch_fault, fetch_fault_pc              (FETCH_ALIGN_EXC_EN only)
// Configuration macro:
//   FETCH_ALIGN_EXC_EN - a misaligned redirect halts fetch and raises
//                        fetch_fault; otherwise the low PC bits are cleared.
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
`ifdef FETCH_ALIGN_EXC_EN
    output logic        fetch_fault,
    output logic [31:0] fetch_fault_pc,
`endif
    input  logic [31:0] redirect_pc
);

    localparam int C_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic [31:0]          hold_addr_q, hold_addr_d;
    logic [C_CNT_W-1:0]   count_q, count_d;
    logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                 instr_valid_q, instr_valid_d;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          instr_pc_q, instr_pc_d;

    logic [31:0]          mem_instr_q [FIFO_DEPTH];
    logic [31:0]          mem_pc_q    [FIFO_DEPTH];

    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic [C_CNT_W-1:0]   w_cnt_after;
    logic [C_CNT_W-1:0]   w_cnt_popped;
    logic [31:0]          w_new_pc;
    logic                 w_aligned;

`ifdef FETCH_ALIGN_EXC_EN
    logic                 halt_pend_q, halt_pend_d;
    logic [31:0]          fault_pc_q, fault_pc_d;
`endif

    // Bus outputs come straight from state so read/address cannot glitch
    // with waitrequest; DISCARD keeps the abandoned address on the bus.
    assign read    = (state_q == S_REQ) || (state_q == S_DISCARD);
    assign address = (state_q == S_DISCARD) ? hold_addr_q : fetch_pc_q;

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

`ifdef FETCH_ALIGN_EXC_EN
    assign fetch_fault    = (state_q == S_HALT);
    assign fetch_fault_pc = fault_pc_q;
    assign w_aligned      = (redirect_pc[1:0] == 2'b00);
`else
    assign w_aligned      = 1'b1;
`endif

    assign w_new_pc     = redirect_pc & ~32'd3;
    assign w_accept     = (state_q == S_REQ) && !waitrequest;
    // A redirect wins over both FIFO operations in the same cycle.
    assign w_push       = w_accept && !redirect_valid;
    assign w_pop        = instr_valid_q && instr_ready && !redirect_valid;
    assign w_cnt_popped = count_q - C_CNT_W'(w_pop);
    assign w_cnt_after  = w_cnt_popped + C_CNT_W'(w_push);

    // ------------------------------------------------------------------
    // Fetch state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        hold_addr_d = hold_addr_q;
`ifdef FETCH_ALIGN_EXC_EN
        halt_pend_d = halt_pend_q;
        fault_pc_d  = fault_pc_q;
`endif

        if (w_accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        // Post-update occupancy decides whether to request next cycle, so a
        // full FIFO restarts fetching in the cycle right after a pop.
        case (state_q)
            S_IDLE: begin
                if (w_cnt_after < C_DEPTH) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (w_accept) begin
                    state_d = (w_cnt_after < C_DEPTH) ? S_REQ : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (!waitrequest) begin
`ifdef FETCH_ALIGN_EXC_EN
                    state_d     = halt_pend_q ? S_HALT : S_REQ;
                    halt_pend_d = 1'b0;
`else
                    state_d     = S_REQ;
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect_valid) begin
            fetch_pc_d = w_new_pc;
            if (read && waitrequest) begin
                // Bus read cannot be withdrawn: finish it and drop the data.
                state_d = S_DISCARD;
                if (state_q == S_REQ) begin
                    hold_addr_d = fetch_pc_q;
                end
`ifdef FETCH_ALIGN_EXC_EN
                halt_pend_d = !w_aligned;
`endif
            end else begin
                state_d = w_aligned ? S_REQ : S_HALT;
`ifdef FETCH_ALIGN_EXC_EN
                halt_pend_d = 1'b0;
`endif
            end
`ifdef FETCH_ALIGN_EXC_EN
            if (!w_aligned) begin
                fault_pc_d = redirect_pc;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Instruction FIFO with registered head
    // ------------------------------------------------------------------
    always_comb begin
        count_d       = w_cnt_after;
        rd_ptr_d      = rd_ptr_q + C_PTR_W'(w_pop);
        wr_ptr_d      = wr_ptr_q + C_PTR_W'(w_push);
        instr_valid_d = (w_cnt_after != '0);
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;

        if (redirect_valid) begin
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            instr_valid_d = 1'b0;
        end else if (w_push && (w_cnt_popped == '0)) begin
            // Word lands in an empty FIFO: bypass storage into the head.
            instr_d    = readdata;
            instr_pc_d = fetch_pc_q;
        end else if (w_cnt_after != '0) begin
            instr_d    = mem_instr_q[rd_ptr_d];
            instr_pc_d = mem_pc_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            mem_instr_q[wr_ptr_q] <= readdata;
            mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_VECTOR;
            hold_addr_q   <= RESET_VECTOR;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
`ifdef FETCH_ALIGN_EXC_EN
            halt_pend_q   <= 1'b0;
            fault_pc_q    <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            hold_addr_q   <= hold_addr_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
`ifdef FETCH_ALIGN_EXC_EN
            halt_pend_q   <= halt_pend_d;
            fault_pc_q    <= fault_pc_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A transaction-level
//               reference model (expected fetch PC, queue of buffered words,
//               discard/halt flags) is stepped once per cycle alongside
//               directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [31:0] C_RV    = 32'hBFC00000;
    localparam int          C_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_EXC_EN
    logic        fetch_fault;
    logic [31:0] fetch_fault_pc;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_VECTOR (C_RV),
        .FIFO_DEPTH   (C_DEPTH)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .read           (read),
        .waitrequest    (waitrequest),
        .readdata       (readdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
`ifdef FETCH_ALIGN_EXC_EN
        .fetch_fault    (fetch_fault),
        .fetch_fault_pc (fetch_fault_pc),
`endif
        .redirect_pc    (redirect_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_hold;
    logic [31:0] m_fault_pc;
    bit          m_disc;
    bit          m_halt;
    bit          m_hpend;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset          = 1'b1;
        waitrequest    = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        readdata       = 32'd0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check_val("rst_read", {31'd0, read}, 32'd0);
        check_val("rst_address", address, C_RV);
        check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_val("rst_instr", instr, 32'd0);
        check_val("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_ALIGN_EXC_EN
        check_val("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check_val("rst_fault_pc", fetch_fault_pc, 32'd0);
`endif
        reset = 1'b0;
        m_q.delete();
        m_pc       = C_RV;
        m_hold     = C_RV;
        m_fault_pc = 32'd0;
        m_disc     = 1'b0;
        m_halt     = 1'b0;
        m_hpend    = 1'b0;
    endtask

    // One clock cycle: check outputs against the model, drive inputs, then
    // advance the model by what the coming rising edge should do.
    task automatic step(input bit wr, input bit rdy, input bit rv, input logic [31:0] rpc);
        bit exp_read;
        bit acc;
        bit pop;
        @(negedge clk);
        exp_read = m_disc || (!m_halt && (m_q.size() < C_DEPTH));
        check_val("read", {31'd0, read}, {31'd0, exp_read});
        if (exp_read) begin
            check_val("address", address, m_disc ? m_hold : m_pc);
        end
        check_val("instr_valid", {31'd0, instr_valid}, {31'd0, (m_q.size() != 0)});
        if (m_q.size() != 0) begin
            check_val("instr", instr, m_q[0].data);
            check_val("instr_pc", instr_pc, m_q[0].pc);
        end
`ifdef FETCH_ALIGN_EXC_EN
        check_val("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_halt});
        if (m_halt) begin
            check_val("fetch_fault_pc", fetch_fault_pc, m_fault_pc);
        end
`endif

        waitrequest    = wr;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        readdata       = wr ? 32'hDEADBEEF : mem_word(address);

        acc = exp_read && !wr;
        pop = (m_q.size() != 0) && rdy;
        if (rv) begin
            if (exp_read && wr) begin
                if (!m_disc) begin
                    m_hold = m_pc;
                end
                m_disc = 1'b1;
            end else begin
                m_disc = 1'b0;
            end
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
`ifdef FETCH_ALIGN_EXC_EN
            if (rpc[1:0] != 2'b00) begin
                m_fault_pc = rpc;
                if (m_disc) begin
                    m_hpend = 1'b1;
                end else begin
                    m_halt = 1'b1;
                end
            end else begin
                m_halt  = 1'b0;
                m_hpend = 1'b0;
            end
`endif
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
            end
            if (acc) begin
                if (m_disc) begin
                    m_disc = 1'b0;
                    if (m_hpend) begin
                        m_halt  = 1'b1;
                        m_hpend = 1'b0;
                    end
                end else begin
                    m_q.push_back({m_pc, mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] tbl [5];
        tbl[0] = 32'hBFC00100;
        tbl[1] = 32'hFFFFFFF8;
        tbl[2] = 32'hBFC00102;
        tbl[3] = 32'hBFC00200;
        tbl[4] = 32'h00000000;

        do_reset(3);

        // Zero-wait stream with decode always ready
        repeat (12) step(1'b0, 1'b1, 1'b0, 32'd0);
        // Decode stalls until the FIFO fills, then resumes
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'd0);
        // Memory stall: address must hold
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0);
        // Redirect during a stalled read
        step(1'b1, 1'b1, 1'b1, 32'hBFC00100);
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'd0);
        // Address wrap
        step(1'b0, 1'b1, 1'b1, 32'hFFFFFFF8);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'd0);
        // Misaligned redirect, then an aligned one
        step(1'b0, 1'b1, 1'b1, 32'hBFC00102);
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'hBFC00200);
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'd0);
        // Misaligned redirect while a read is stalled
        step(1'b1, 1'b1, 1'b1, 32'hBFC00102);
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'hBFC00200);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit          wr;
            bit          rdy;
            bit          rv;
            logic [31:0] rpc;
            wr  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            tbl[4] = $urandom;
            rpc = tbl[$urandom_range(0, 4)];
            step(wr, rdy, rv, rpc);
        end

        // Reset after traffic must clear the registered head
        do_reset(2);
        repeat (8) step(1'b0, 1'b1, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
